// File: rtl/aes_key_sched.sv
// -----------------------------------------------------------------------------
// aes_key_sched -- sequential AES-128 round-key generator.
//
// Expands a 128-bit cipher key into round keys 0..10 and hands them out one
// per valid/ready handshake. Keys are computed on the fly: only the current
// round key and rcon are held, and SubWord uses four aes_sbox instances.
//
// Byte layout (rk and key_in): byte 15 is the first key byte. Word wN is
// {rk[15-4N], rk[14-4N], rk[13-4N], rk[12-4N]}, high byte = row 0.
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   start     in   load key_in and begin an expansion (sampled in IDLE only)
//   key_in    in   [7:0] x16 cipher key
//   rk_ready  in   consumer accepts rk this cycle
//   rk_valid  out  rk / rk_round valid
//   rk        out  [7:0] x16 current round key
//   rk_round  out  [3:0] round index 0..10
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse after round key 10 is accepted
//
// Build option: define AES_KEY_SCHED_FAST_EN to drop the GEN state and load
// the next key straight on the handshake edge (one key per cycle).
// -----------------------------------------------------------------------------

// Combinational AES S-box: multiplicative inverse in GF(2^8) + affine map.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  logic [7:0] inv;

  assign inv   = gf_inv(in_i);
  assign out_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

module aes_key_sched (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] key_in [15:0],
  input  logic       rk_ready,
  output logic       rk_valid,
  output logic [7:0] rk [15:0],
  output logic [3:0] rk_round,
  output logic       busy,
  output logic       done
);

  localparam int unsigned NBYTES   = 16;
  localparam int unsigned LAST_RND = 10;

`ifdef AES_KEY_SCHED_FAST_EN
  typedef enum logic [1:0] {S_IDLE, S_OUT} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_OUT, S_GEN} state_e;
`endif

  state_e     state_q, state_d;
  logic [7:0] rk_q [NBYTES-1:0];
  logic [7:0] rk_d [NBYTES-1:0];
  logic [3:0] round_q, round_d;
  logic [7:0] rcon_q, rcon_d;
  logic       valid_q, busy_q, done_q, done_d;

  // Next round key, derived combinationally from the current one.
  logic [127:0] rk_flat;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] nk_flat;
  logic [7:0]   nk [NBYTES-1:0];
  logic [7:0]   sub_b [4];
  logic [7:0]   rcon_nx;

  always_comb begin
    for (int i = 0; i < NBYTES; i++) rk_flat[8*i +: 8] = rk_q[i];
  end

  assign w0  = rk_flat[127:96];
  assign w1  = rk_flat[95:64];
  assign w2  = rk_flat[63:32];
  assign w3  = rk_flat[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (rot[8*g +: 8]),
      .out_o (sub_b[g])
    );
  end

  assign sub     = {sub_b[3], sub_b[2], sub_b[1], sub_b[0]};
  assign t       = sub ^ {rcon_q, 24'h000000};
  assign n0      = w0 ^ t;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign nk_flat = {n0, n1, n2, n3};

  always_comb begin
    for (int i = 0; i < NBYTES; i++) nk[i] = nk_flat[8*i +: 8];
  end

  // xtime: multiply rcon by x in GF(2^8).
  assign rcon_nx = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NBYTES; i++) rk_q[i] <= 8'h00;
      round_q <= 4'd0;
      rcon_q  <= 8'h01;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NBYTES; i++) rk_q[i] <= rk_d[i];
      round_q <= round_d;
      rcon_q  <= rcon_d;
      valid_q <= (state_d == S_OUT);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < NBYTES; i++) rk_d[i] = rk_q[i];
    round_d = round_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int i = 0; i < NBYTES; i++) rk_d[i] = key_in[i];
          round_d = 4'd0;
          rcon_d  = 8'h01;
          state_d = S_OUT;
        end
      end

      S_OUT: begin
        if (rk_ready) begin
          if (round_q == 4'(LAST_RND)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
`ifdef AES_KEY_SCHED_FAST_EN
            for (int i = 0; i < NBYTES; i++) rk_d[i] = nk[i];
            round_d = round_q + 4'd1;
            rcon_d  = rcon_nx;
`else
            state_d = S_GEN;
`endif
          end
        end
      end

`ifndef AES_KEY_SCHED_FAST_EN
      S_GEN: begin
        for (int i = 0; i < NBYTES; i++) rk_d[i] = nk[i];
        round_d = round_q + 4'd1;
        rcon_d  = rcon_nx;
        state_d = S_OUT;
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  assign rk_valid = valid_q;
  assign rk       = rk_q;
  assign rk_round = round_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_key_sched.sv
// -----------------------------------------------------------------------------
// tb_aes_key_sched -- directed bench for aes_key_sched: FIPS-197 key with
// ready high, backpressure, start-while-busy, random ready, reset during an
// expansion followed by an all-zero key, and back-to-back starts.
// -----------------------------------------------------------------------------
module tb_aes_key_sched;

`ifdef AES_KEY_SCHED_FAST_EN
  localparam int DONE_FULL = 13;
`else
  localparam int DONE_FULL = 23;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] key_in [15:0];
  logic       rk_ready;
  logic       rk_valid;
  logic [7:0] rk [15:0];
  logic [3:0] rk_round;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] fips_rk [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic [127:0] zero_rk [11] = '{
    128'h00000000000000000000000000000000,
    128'h62636363626363636263636362636363,
    128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
    128'h0, 128'h0, 128'h0, 128'h0, 128'h0, 128'h0, 128'h0, 128'h0
  };

  logic [127:0] exp_rk [11];

  aes_key_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .rk_ready (rk_ready),
    .rk_valid (rk_valid),
    .rk       (rk),
    .rk_round (rk_round),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rk_flat();
    logic [127:0] p;
    for (int i = 0; i < 16; i++) p[8*i +: 8] = rk[i];
    return p;
  endfunction

  task automatic set_key(input logic [127:0] k);
    for (int i = 0; i < 16; i++) key_in[i] = k[8*i +: 8];
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one expansion starting in the current cycle (cycle 1 = start cycle);
  // returns at the sample point of the done cycle.
  task automatic expand(input logic [127:0] key, input int key_chk_max,
                        input int stall_round, input int stall_len,
                        input bit rand_rdy, input int poke_round,
                        input int exp_done_cycle);
    int c;
    int nxt;
    int stall_left;
    int ndone;
    bit stalled;
    bit poked;
    set_key(key);
    start    = 1'b1;
    rk_ready = 1'b1;
    step();
    start = 1'b0;
    c     = 2;
    check("r0_valid", 128'(rk_valid), 128'd1);
    check("r0_round", 128'(rk_round), 128'd0);
    check("r0_busy",  128'(busy),     128'd1);
    check("r0_done",  128'(done),     128'd0);
    check("r0_key",   rk_flat(),      exp_rk[0]);
    nxt = 0; stall_left = 0; ndone = 0; stalled = 1'b0; poked = 1'b0;
    while (c < 400 && ndone == 0) begin
      start = 1'b0;
      if (!stalled && rk_valid && int'(rk_round) == stall_round) begin
        stalled    = 1'b1;
        stall_left = stall_len;
      end
      if (stall_left > 0) begin
        rk_ready = 1'b0;
        stall_left--;
        check("hold_valid", 128'(rk_valid), 128'd1);
        check("hold_round", 128'(rk_round), 128'(stall_round));
        check("hold_key",   rk_flat(),      exp_rk[stall_round]);
      end else begin
        rk_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (!poked && rk_valid && int'(rk_round) == poke_round) begin
        poked = 1'b1;
        start = 1'b1;
        set_key(~key);
      end
      if (rk_valid && rk_ready) begin
        check("acc_round", 128'(rk_round), 128'(nxt));
        if (nxt <= key_chk_max && nxt < 11) check("acc_key", rk_flat(), exp_rk[nxt]);
        nxt++;
      end
      step();
      c++;
      if (done) ndone++;
    end
    start = 1'b0;
    check("n_accepted", 128'(nxt),   128'd11);
    check("done_seen",  128'(ndone), 128'd1);
    if (exp_done_cycle > 0) check("done_cycle", 128'(c), 128'(exp_done_cycle));
    check("done_busy",  128'(busy),     128'd0);
    check("done_valid", 128'(rk_valid), 128'd0);
  endtask

  initial begin
    int c;
    rst_n    = 1'b0;
    start    = 1'b0;
    rk_ready = 1'b0;
    set_key(128'h0);
    #12;
    check("rst_valid", 128'(rk_valid), 128'd0);
    check("rst_busy",  128'(busy),     128'd0);
    check("rst_done",  128'(done),     128'd0);
    check("rst_round", 128'(rk_round), 128'd0);
    check("rst_key",   rk_flat(),      128'h0);
    rst_n = 1'b1;
    step();

    // FIPS-197 key, ready held high.
    exp_rk = fips_rk;
    expand(fips_rk[0], 10, -1, 0, 1'b0, -1, DONE_FULL);
    // Back-to-back start in the done cycle, stalled for 5 cycles at round 4.
    expand(fips_rk[0], 10, 4, 5, 1'b0, -1, DONE_FULL + 5);
    // Start pulsed with a different key during round 2 is ignored.
    expand(fips_rk[0], 10, -1, 0, 1'b0, 2, DONE_FULL);
    // Random ready.
    expand(fips_rk[0], 10, -1, 0, 1'b1, -1, -1);

    // Reset during round 6.
    set_key(fips_rk[0]);
    start    = 1'b1;
    rk_ready = 1'b1;
    step();
    start = 1'b0;
    c = 0;
    while (c < 60 && !(rk_valid && rk_round == 4'd6)) begin
      step();
      c++;
    end
    check("mid_round6", 128'(rk_round), 128'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(rk_valid), 128'd0);
    check("mid_rst_busy",  128'(busy),     128'd0);
    check("mid_rst_done",  128'(done),     128'd0);
    check("mid_rst_round", 128'(rk_round), 128'd0);
    check("mid_rst_key",   rk_flat(),      128'h0);
    step();
    #2;
    rst_n = 1'b1;
    step();
    check("post_rst_idle", 128'(busy), 128'd0);

    // All-zero key after reset.
    exp_rk = zero_rk;
    expand(128'h0, 2, -1, 0, 1'b0, -1, DONE_FULL);

    step();
    check("final_done_low", 128'(done), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_key_sched.md
# aes_key_sched

Sequential AES-128 round-key generator that expands a 128-bit cipher key into round keys 0–10, one per handshake. It feeds the AddRoundKey stage that consumes the MixColumns output, so each round key must match the byte layout of the round state. It computes on the fly, stores no key table, and uses four S-box lookups per round.

## Interface
- No parameters; the key size is fixed at 128 bits and there are 10 rounds.
- `clk`  in  1  — single clock domain.
- `rst_n`  in  1  — reset, asynchronous assert, active-low.
- `start`  in  1  — load `key_in` and begin an expansion. Sampled only in IDLE.
- `key_in`  in  [7:0] x16 (unpacked `[7:0] key_in [15:0]`)  — cipher key. Byte 15 is the first key byte.
- `rk_ready`  in  1  — the consumer accepts `rk` this cycle.
- `rk_valid`  out  1  — `rk` and `rk_round` are valid.
- `rk`  out  [7:0] x16 (unpacked)  — current round key, same layout as `key_in`.
- `rk_round`  out  4  — index of `rk`, from 0 to 10.
- `busy`  out  1  — high in every state except IDLE.
- `done`  out  1  — one-cycle pulse after round key 10 is accepted.

## Operation
- **Word mapping:**
  - w0 = {rk[15],rk[14],rk[13],rk[12]}, …, w3 = {rk[3],rk[2],rk[1],rk[0]}.
  - The byte with the highest index is the most significant byte of each word, i.e. row 0 of the column.
- **States:** IDLE, OUT, GEN.
  - IDLE: when `start`=1, register `key_in` into `rk`, set `rk_round`=0 and rcon=8'h01, then go to OUT.
  - OUT: `rk_valid`=1. On `rk_valid & rk_ready`:
    - if `rk_round`==10, go to IDLE and pulse `done`;
    - otherwise go to GEN.
  - GEN: compute the next key in one cycle and go to OUT.
- **Next-key computation in GEN:**
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}. RotWord moves {b0,b1,b2,b3} to {b1,b2,b3,b0}.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - `rk_round` increments by 1.
  - rcon updates by xtime: shift left by 1, and XOR with 8'h1B if bit 7 was set. The sequence is 01,02,04,08,10,20,40,80,1B,36.
- SubWord instantiates four `aes_sbox` (the existing combinational 8-bit S-box), one per byte.
- `rk` and `rk_round` hold stable while `rk_valid`=1 and `rk_ready`=0. Backpressure can be held for any length of time.
- `start` is ignored while `busy`=1. It cannot abort or restart an expansion in progress.
- **Reset** (asynchronous, at any point including mid-expansion):
  - state goes to IDLE;
  - `rk` is all bytes 8'h00, `rk_round`=0, rcon=8'h01;
  - `rk_valid`=0, `busy`=0, `done`=0.

## Timing
- `start` high at edge t: `rk_valid`=1 with round 0 from cycle t+1.
- Handshake at edge t: in the default build, the next `rk_valid` rises at t+2, after one GEN bubble. Cadence is 2 cycles per key.
- Full expansion with `rk_ready` held high:
  - 1 + 11 + 10 = 22 cycles from `start` to the final accept.
  - `done` is high on the cycle after the accept of round 10.
- `busy` falls in the same cycle that `done` rises.
- A new `start` is accepted in the `done` cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `AES_KEY_SCHED_FAST_EN` defined:
  - The GEN state is removed.
  - The next key is computed combinationally from the current `rk` and loaded on the handshake edge.
  - `rk_valid` stays high across rounds 0–10, giving one key per cycle with `rk_ready`=1.
  - Full expansion takes 12 cycles from `start` to the final accept.
- Not defined: 2-cycle cadence as described above, with the S-box path registered through GEN.
- Key values, ordering, backpressure, `done` and reset behaviour are identical in both builds.

## Test plan
- **FIPS-197 key, ready held high.** Stimulus: `key_in` = 2b7e151628aed2a6abf7158809cf4f3c (byte 15 = 2b), `rk_ready`=1. Required response:
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - `done` pulses once, on cycle 23 (default build) or cycle 13 (FAST build).
- **Backpressure.** Same key, `rk_ready` low for 5 cycles during round 4. Required response: `rk`, `rk_round`=4 and `rk_valid` hold constant; all later keys are unchanged.
- **Random ready.** Same key, `rk_ready` toggled randomly. Required response: exactly 11 accepted keys, with `rk_round` values 0..10 in order and no duplicates or skips.
- **Start while busy.** `start` pulsed with a different key during round 2. Required response: it is ignored, and the key sequence still matches the first key.
- **Reset mid-expansion.** `rst_n` asserted during round 6. Required response: outputs go to zero immediately. A subsequent `start` with key all-zero gives round 1 = 62636363626363636263636362636363.
- **Back-to-back.** `start` asserted in the `done` cycle. Required response: the new expansion's round 0 appears on the next cycle.
